playback_controller: RTL and testbench

Sequencer for the tone datapath: replaces the free-running strobe-plus-sequence-counter path with a controlled player. It adds start/stop/pause, selectable tempo, per-note length in beats, rests, an inter-note articulation gap and optional looping. It drives the notes ROM index and a mute gate in front of the PWM modulator output. It sits between the top-level user inputs and the ROM/PWM datapath.

---
 rtl/playback_controller_pkg.sv | 12 +
 rtl/playback_controller_beat_timer.sv | 47 ++++
 rtl/playback_controller.sv | 124 ++++++++++++
 tb/tb_playback_controller.sv | 278 +++++++++++++++++++++++++++
 4 files changed

// File: rtl/playback_controller_pkg.sv
// Shared encodings for the tone playback sequencer.
package playback_controller_pkg;

   typedef enum logic [1:0] {
      ST_IDLE  = 2'd0,
      ST_PLAY  = 2'd1,
      ST_PAUSE = 2'd2
   } state_e;

   localparam int TEMPO_BW = 2;

endpackage

// File: rtl/playback_controller_beat_timer.sv
// Reloadable beat down-counter; the period is BEAT_CYCLES shifted right by the tempo code.
module beat_timer
   import playback_controller_pkg::*;
#(
   parameter int unsigned     BW          = 24,
   parameter logic [BW-1:0]   BEAT_CYCLES = 24'd2400000,
   parameter logic [BW-1:0]   GAP_CYCLES  = 24'd120000
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   input  logic                clear_i,
   input  logic                load_i,
   input  logic                en_i,
   input  logic [TEMPO_BW-1:0] tempo_i,
   output logic                tick_o,
   output logic                in_gap_o
);

   logic [BW-1:0] cnt_q;
   logic [BW-1:0] cnt_d;
   logic [BW-1:0] period;

   // Tempo is only looked at when the counter reloads, so a beat in flight keeps its length.
   assign period   = BEAT_CYCLES >> tempo_i;
   assign tick_o   = en_i & (cnt_q == '0);
   assign in_gap_o = cnt_q < GAP_CYCLES;

   always_comb begin
      cnt_d = cnt_q;
      if (clear_i) begin
         cnt_d = '0;
      end else if (load_i) begin
         cnt_d = period - BW'(1);
      end else if (en_i) begin
         cnt_d = (cnt_q == '0) ? period - BW'(1) : cnt_q - BW'(1);
      end
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         cnt_q <= '0;
      end else begin
         cnt_q <= cnt_d;
      end
   end

endmodule

// File: rtl/playback_controller.sv
// Controlled note player: steps the notes ROM index by beats and gates the PWM output with mute_o.
module playback_controller
   import playback_controller_pkg::*;
#(
   parameter int unsigned   BW          = 24,
   parameter logic [BW-1:0] BEAT_CYCLES = 24'd2400000,
   parameter logic [BW-1:0] GAP_CYCLES  = 24'd120000,
   parameter int unsigned   IDX_BW      = 6,
   parameter int unsigned   SEQ_LEN     = 64
) (
   input  logic                clk_i,
   input  logic                rst_n_i,
   input  logic                start_i,
   input  logic                stop_i,
   input  logic                pause_i,
   input  logic                loop_i,
   input  logic [1:0]          tempo_i,
   input  logic [1:0]          lenCode_i,
   input  logic                isRest_i,
   output logic [IDX_BW-1:0]   noteIndex_o,
   output logic                mute_o,
   output logic                playing_o,
   output logic                songEnd_o
);

   localparam logic [IDX_BW-1:0] LAST_IDX = IDX_BW'(SEQ_LEN - 1);

   state_e            state_q, state_d;
   logic [IDX_BW-1:0] idx_q, idx_d;
   logic [1:0]        beat_num_q, beat_num_d;
   logic              song_end_q, song_end_d;
   logic              playing_q, playing_d;

   logic timer_clear;
   logic timer_load;
   logic timer_en;
   logic tick;
   logic in_gap;

   // Counting happens in any active cycle without pause, including the cycle that leaves PAUSE.
   assign timer_en = (state_q != ST_IDLE) & ~pause_i & ~stop_i & ~start_i;

   beat_timer #(
      .BW          (BW),
      .BEAT_CYCLES (BEAT_CYCLES),
      .GAP_CYCLES  (GAP_CYCLES)
   ) u_beat_timer (
      .clk_i    (clk_i),
      .rst_n_i  (rst_n_i),
      .clear_i  (timer_clear),
      .load_i   (timer_load),
      .en_i     (timer_en),
      .tempo_i  (tempo_i),
      .tick_o   (tick),
      .in_gap_o (in_gap)
   );

   always_comb begin
      state_d     = state_q;
      idx_d       = idx_q;
      beat_num_d  = beat_num_q;
      song_end_d  = 1'b0;
      timer_clear = 1'b0;
      timer_load  = 1'b0;
      if (stop_i) begin
         state_d     = ST_IDLE;
         idx_d       = '0;
         beat_num_d  = '0;
         timer_clear = 1'b1;
      end else if (start_i) begin
         state_d    = ST_PLAY;
         idx_d      = '0;
         beat_num_d = '0;
         timer_load = 1'b1;
      end else if (state_q != ST_IDLE) begin
         if (pause_i) begin
            state_d = ST_PAUSE;
         end else begin
            state_d = ST_PLAY;
            if (tick) begin
               if (beat_num_q == lenCode_i) begin
                  beat_num_d = '0;
                  if (idx_q == LAST_IDX) begin
                     song_end_d = 1'b1;
                     idx_d      = '0;
                     if (!loop_i) begin
                        state_d     = ST_IDLE;
                        timer_clear = 1'b1;
                     end
                  end else begin
                     idx_d = idx_q + IDX_BW'(1);
                  end
               end else begin
                  beat_num_d = beat_num_q + 2'd1;
               end
            end
         end
      end
      playing_d = (state_d != ST_IDLE);
   end

   always_ff @(posedge clk_i or negedge rst_n_i) begin
      if (!rst_n_i) begin
         state_q    <= ST_IDLE;
         idx_q      <= '0;
         beat_num_q <= '0;
         song_end_q <= 1'b0;
         playing_q  <= 1'b0;
      end else begin
         state_q    <= state_d;
         idx_q      <= idx_d;
         beat_num_q <= beat_num_d;
         song_end_q <= song_end_d;
         playing_q  <= playing_d;
      end
   end

   // The articulation gap covers the tail of the last beat of each note.
   assign mute_o      = (state_q != ST_PLAY) | isRest_i | ((beat_num_q == lenCode_i) & in_gap);
   assign noteIndex_o = idx_q;
   assign playing_o   = playing_q;
   assign songEnd_o   = song_end_q;

endmodule

// File: tb/tb_playback_controller.sv
// Scoreboard bench for playback_controller: 16-cycle beats, 2-cycle gap, 4-note song.
module tb_playback_controller;

   logic       clk_i = 1'b0;
   logic       rst_n_i;
   logic       start_i;
   logic       stop_i;
   logic       pause_i;
   logic       loop_i;
   logic [1:0] tempo_i;
   logic [1:0] lenCode_i;
   logic       isRest_i;
   logic [5:0] noteIndex_o;
   logic       mute_o;
   logic       playing_o;
   logic       songEnd_o;

   // ROM stand-in: one note may be lengthened, one may be a rest.
   logic [5:0] len_note  = 6'h3f;
   logic [1:0] len_val   = 2'd0;
   logic [5:0] rest_note = 6'h3f;
   assign lenCode_i = (noteIndex_o == len_note) ? len_val : 2'd0;
   assign isRest_i  = (noteIndex_o == rest_note);

   playback_controller #(
      .BW          (24),
      .BEAT_CYCLES (24'd16),
      .GAP_CYCLES  (24'd2),
      .IDX_BW      (6),
      .SEQ_LEN     (4)
   ) dut (
      .clk_i       (clk_i),
      .rst_n_i     (rst_n_i),
      .start_i     (start_i),
      .stop_i      (stop_i),
      .pause_i     (pause_i),
      .loop_i      (loop_i),
      .tempo_i     (tempo_i),
      .lenCode_i   (lenCode_i),
      .isRest_i    (isRest_i),
      .noteIndex_o (noteIndex_o),
      .mute_o      (mute_o),
      .playing_o   (playing_o),
      .songEnd_o   (songEnd_o)
   );

   always #5 clk_i = ~clk_i;

   int cyc = 0;
   always @(posedge clk_i) cyc <= cyc + 1;

   typedef struct {
      int         cyc;
      logic [5:0] idx;
      logic       se;
      logic       pl;
      logic       mu;
   } exp_t;

   exp_t sb[$];
   int   total = 0;
   int   bad   = 0;

   task automatic checkOutput(input string tag, input logic [31:0] actual, input logic [31:0] expected);
      total++;
      if (actual !== expected) begin
         bad++;
         $display("[TB] FAIL %s actual=%0h expected=%0h", tag, actual, expected);
      end
   endtask

   task automatic expectAt(input int c, input logic [5:0] idx, input logic se, input logic pl, input logic mu);
      exp_t e;
      e.cyc = c;
      e.idx = idx;
      e.se  = se;
      e.pl  = pl;
      e.mu  = mu;
      sb.push_back(e);
   endtask

   // Caller sits on a negedge; the pulse is seen by the next posedge.
   task automatic applyStimulus(input logic st, input logic sp, output int eff);
      start_i = st;
      stop_i  = sp;
      eff     = cyc + 1;
   endtask

   task automatic endPulse();
      @(negedge clk_i);
      start_i = 1'b0;
      stop_i  = 1'b0;
   endtask

   task automatic waitCycle(input int c);
      while (cyc < c) @(negedge clk_i);
   endtask

   task automatic drain();
      int n = 0;
      while (sb.size() > 0 && n < 400) begin
         @(negedge clk_i);
         n++;
      end
      if (sb.size() > 0) begin
         checkOutput("drain_timeout", sb.size(), 0);
         sb.delete();
      end
   endtask

   // Pops every expectation whose cycle has arrived and compares all outputs.
   always @(negedge clk_i) begin
      exp_t e;
      while (sb.size() > 0 && sb[0].cyc <= cyc) begin
         e = sb.pop_front();
         checkOutput($sformatf("c%0d_idx", e.cyc), 32'(noteIndex_o), 32'(e.idx));
         checkOutput($sformatf("c%0d_end", e.cyc), 32'(songEnd_o), 32'(e.se));
         checkOutput($sformatf("c%0d_play", e.cyc), 32'(playing_o), 32'(e.pl));
         checkOutput($sformatf("c%0d_mute", e.cyc), 32'(mute_o), 32'(e.mu));
      end
   end

   initial begin
      #100000;
      $display("[TB] FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "[TB] watchdog");
   end

   initial begin
      int s;
      int r;
      int x;
      rst_n_i = 1'b0;
      start_i = 1'b0;
      stop_i  = 1'b0;
      pause_i = 1'b0;
      loop_i  = 1'b0;
      tempo_i = 2'd0;
      repeat (3) @(negedge clk_i);
      checkOutput("rst_idx", 32'(noteIndex_o), 0);
      checkOutput("rst_play", 32'(playing_o), 0);
      checkOutput("rst_end", 32'(songEnd_o), 0);
      checkOutput("rst_mute", 32'(mute_o), 1);
      rst_n_i = 1'b1;
      @(negedge clk_i);
      checkOutput("idle_play", 32'(playing_o), 0);

      $display("[TB] basic song");
      applyStimulus(1'b1, 1'b0, s);
      expectAt(s,      0, 0, 1, 0);
      expectAt(s + 13, 0, 0, 1, 0);
      expectAt(s + 14, 0, 0, 1, 1);
      expectAt(s + 15, 0, 0, 1, 1);
      expectAt(s + 16, 1, 0, 1, 0);
      expectAt(s + 32, 2, 0, 1, 0);
      expectAt(s + 48, 3, 0, 1, 0);
      expectAt(s + 63, 3, 0, 1, 1);
      expectAt(s + 64, 0, 1, 0, 1);
      expectAt(s + 65, 0, 0, 0, 1);
      endPulse();
      drain();

      $display("[TB] tempo change mid-beat");
      applyStimulus(1'b1, 1'b0, s);
      expectAt(s + 15, 0, 0, 1, 1);
      expectAt(s + 16, 1, 0, 1, 0);
      expectAt(s + 19, 1, 0, 1, 1);
      expectAt(s + 20, 2, 0, 1, 0);
      expectAt(s + 24, 3, 0, 1, 0);
      expectAt(s + 28, 0, 1, 0, 1);
      endPulse();
      waitCycle(s + 3);
      tempo_i = 2'd2;
      drain();
      tempo_i = 2'd0;

      $display("[TB] loop at tempo 2");
      loop_i  = 1'b1;
      tempo_i = 2'd2;
      applyStimulus(1'b1, 1'b0, s);
      expectAt(s,      0, 0, 1, 0);
      expectAt(s + 2,  0, 0, 1, 1);
      expectAt(s + 4,  1, 0, 1, 0);
      expectAt(s + 12, 3, 0, 1, 0);
      expectAt(s + 16, 0, 1, 1, 0);
      expectAt(s + 17, 0, 0, 1, 0);
      expectAt(s + 20, 1, 0, 1, 0);
      expectAt(s + 21, 1, 0, 1, 0);
      endPulse();
      waitCycle(s + 21);
      applyStimulus(1'b0, 1'b1, x);
      expectAt(x, 0, 0, 0, 1);
      endPulse();
      drain();
      loop_i  = 1'b0;
      tempo_i = 2'd0;

      $display("[TB] long note and rest");
      len_note  = 6'd1;
      len_val   = 2'd2;
      rest_note = 6'd2;
      applyStimulus(1'b1, 1'b0, s);
      expectAt(s + 16, 1, 0, 1, 0);
      expectAt(s + 32, 1, 0, 1, 0);
      expectAt(s + 47, 1, 0, 1, 0);
      expectAt(s + 61, 1, 0, 1, 0);
      expectAt(s + 62, 1, 0, 1, 1);
      expectAt(s + 63, 1, 0, 1, 1);
      expectAt(s + 64, 2, 0, 1, 1);
      expectAt(s + 72, 2, 0, 1, 1);
      expectAt(s + 79, 2, 0, 1, 1);
      expectAt(s + 80, 3, 0, 1, 0);
      expectAt(s + 96, 0, 1, 0, 1);
      endPulse();
      drain();
      len_note  = 6'h3f;
      len_val   = 2'd0;
      rest_note = 6'h3f;

      $display("[TB] pause for 10 cycles");
      applyStimulus(1'b1, 1'b0, s);
      expectAt(s + 5,  0, 0, 1, 1);
      expectAt(s + 14, 0, 0, 1, 1);
      expectAt(s + 15, 0, 0, 1, 0);
      expectAt(s + 23, 0, 0, 1, 0);
      expectAt(s + 25, 0, 0, 1, 1);
      expectAt(s + 26, 1, 0, 1, 0);
      expectAt(s + 74, 0, 1, 0, 1);
      endPulse();
      waitCycle(s + 4);
      pause_i = 1'b1;
      waitCycle(s + 14);
      pause_i = 1'b0;
      drain();

      $display("[TB] restart and start with stop");
      applyStimulus(1'b1, 1'b0, s);
      expectAt(s,      0, 0, 1, 0);
      expectAt(s + 16, 1, 0, 1, 0);
      endPulse();
      waitCycle(s + 20);
      applyStimulus(1'b1, 1'b0, r);
      expectAt(r,      0, 0, 1, 0);
      expectAt(r + 15, 0, 0, 1, 1);
      expectAt(r + 16, 1, 0, 1, 0);
      endPulse();
      waitCycle(r + 19);
      applyStimulus(1'b1, 1'b1, x);
      expectAt(x,     0, 0, 0, 1);
      expectAt(x + 3, 0, 0, 0, 1);
      endPulse();
      drain();

      $display("[TB] async reset mid-note");
      applyStimulus(1'b1, 1'b0, s);
      expectAt(s + 16, 1, 0, 1, 0);
      endPulse();
      drain();
      waitCycle(s + 20);
      checkOutput("pre_rst_idx", 32'(noteIndex_o), 1);
      #2 rst_n_i = 1'b0;
      #1;
      checkOutput("async_idx", 32'(noteIndex_o), 0);
      checkOutput("async_play", 32'(playing_o), 0);
      checkOutput("async_mute", 32'(mute_o), 1);
      checkOutput("async_end", 32'(songEnd_o), 0);
      @(negedge clk_i);
      rst_n_i = 1'b1;
      @(negedge clk_i);
      checkOutput("post_rst_play", 32'(playing_o), 0);
      checkOutput("post_rst_idx", 32'(noteIndex_o), 0);

      drain();
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
